// File: rtl/phase_sched.sv
// phase_sched: per-sample phase scheduler for a derotator.
// Accumulates a per-sample frequency increment, adds a per-symbol pilot
// correction, and hands a wrapped phase to the rotator with a one-cycle strobe.
// Optional feature macro: PHASE_SCHED_CP_ADVANCE_EN -- on each symbol boundary
// the accumulator additionally advances by 16*inc to cover the removed cyclic
// prefix. Without the macro every sample advances the accumulator by inc.
`timescale 1ns/1ps

module phase_sched #(
    parameter int PI            = 1608,
    parameter int SYM_LEN_SHIFT = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     stop,
    input  logic [15:0]              freq_offset,
    input  logic                     sample_in_stb,
    input  logic [15:0]              pilot_phase,
    input  logic                     pilot_phase_valid,
    output logic [15:0]              phase,
    output logic                     phase_stb,
    output logic [SYM_LEN_SHIFT-1:0] sample_idx,
    output logic [7:0]               symbol_count,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    localparam logic signed [16:0] PI17     = 17'(PI);
    localparam logic signed [16:0] TWO_PI17 = 17'(2 * PI);

    // Bring a 17-bit sum of two in-range phases back into [-PI, PI].
    // Both operands are already in range, so a single correction suffices.
    function automatic logic signed [15:0] wrap(input logic signed [16:0] x);
        logic signed [16:0] y;
        if (x > PI17) begin
            y = x - TWO_PI17;
        end else if (x < -PI17) begin
            y = x + TWO_PI17;
        end else begin
            y = x;
        end
        return 16'(y);
    endfunction

    state_t             state;
    logic signed [15:0] inc;         // per-sample increment captured in LOAD
    logic signed [15:0] acc;         // running carrier phase
    logic signed [15:0] corr;        // pilot correction active this symbol
    logic signed [15:0] pend;        // newest pilot correction for next symbol
    logic               pend_valid;

    logic signed [15:0] phase_next;   // phase handed out for the current sample
    logic signed [15:0] acc_step;     // accumulator after an ordinary sample
    logic signed [15:0] acc_boundary; // accumulator after a boundary sample
    logic               boundary;     // current sample closes the symbol

    assign boundary = &sample_idx;
    assign busy     = (state != S_IDLE);

`ifdef PHASE_SCHED_CP_ADVANCE_EN
    localparam logic signed [19:0] TWO_PI20 = 20'(2 * PI);

    logic signed [19:0] inc_x16;  // 16*inc, exact in 20 bits for |inc| <= PI
    logic signed [19:0] cp_rem;   // 16*inc reduced modulo 2*PI
    logic signed [15:0] cp_adv;   // cyclic-prefix advance folded into [-PI, PI]

    // Cyclic-prefix advance depends only on inc, so it is a static function of LOAD.
    always_comb begin
        inc_x16 = {inc, 4'b0000};
        cp_rem  = inc_x16 % TWO_PI20;
        cp_adv  = wrap(17'(cp_rem));
    end
`endif

    // Next-phase arithmetic shared by every TRACK sample.
    // NOTE: every output of an always_comb gets a value on every path; a missing
    // assignment would silently become a latch.
    always_comb begin
        phase_next = wrap({acc[15], acc} + {corr[15], corr});
        acc_step   = wrap({acc[15], acc} + {inc[15], inc});
`ifdef PHASE_SCHED_CP_ADVANCE_EN
        acc_boundary = wrap({acc_step[15], acc_step} + {cp_adv[15], cp_adv});
`else
        acc_boundary = acc_step;
`endif
    end

    // Control FSM plus all datapath registers, with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            inc          <= '0;
            acc          <= '0;
            corr         <= '0;
            pend         <= '0;
            pend_valid   <= 1'b0;
            phase        <= '0;
            phase_stb    <= 1'b0;
            sample_idx   <= '0;
            symbol_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so this default is simply
            // overridden by a later assignment in the same cycle; the strobe is a
            // single-cycle pulse unless a sample is taken right now.
            phase_stb <= 1'b0;

            if (enable) begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            state <= S_LOAD;
                        end
                    end

                    S_LOAD: begin
                        inc          <= freq_offset;
                        acc          <= '0;
                        corr         <= '0;
                        pend         <= '0;
                        pend_valid   <= 1'b0;
                        sample_idx   <= '0;
                        symbol_count <= '0;
                        state        <= stop ? S_IDLE : S_TRACK;
                    end

                    S_TRACK: begin
                        if (stop) begin
                            state <= S_IDLE;
                        end else if (start) begin
                            // Restart: LOAD clears acc and any pending correction.
                            state <= S_LOAD;
                        end else begin
                            if (sample_in_stb) begin
                                phase      <= phase_next;
                                phase_stb  <= 1'b1;
                                sample_idx <= sample_idx + SYM_LEN_SHIFT'(1);
                                acc        <= boundary ? acc_boundary : acc_step;
                            end

                            if (sample_in_stb && boundary) begin
                                // A pilot arriving on the boundary sample is applied
                                // directly; otherwise the pending one takes effect.
                                if (pilot_phase_valid) begin
                                    corr <= pilot_phase;
                                end else if (pend_valid) begin
                                    corr <= pend;
                                end
                                pend_valid <= 1'b0;
                                if (symbol_count != 8'hFF) begin
                                    symbol_count <= symbol_count + 8'd1;
                                end
                            end else if (pilot_phase_valid) begin
                                // Newest pilot wins; it waits for the next boundary.
                                pend       <= pilot_phase;
                                pend_valid <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_sched.sv
// tb_phase_sched: directed stimulus for phase_sched with an integer-level
// behavioural model compared against the DUT on every cycle, plus literal
// expectations for the documented scenarios.
`timescale 1ns/1ps

module tb_phase_sched;

    localparam int PI  = 1608;
    localparam int SLS = 6;
    localparam int N   = 1 << SLS;

`ifdef PHASE_SCHED_CP_ADVANCE_EN
    localparam int EXP_CP_64 = 800;
`else
    localparam int EXP_CP_64 = 640;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] freq_offset = '0;
    logic        sample_in_stb = 1'b0;
    logic [15:0] pilot_phase = '0;
    logic        pilot_phase_valid = 1'b0;

    logic [15:0]    phase;
    logic           phase_stb;
    logic [SLS-1:0] sample_idx;
    logic [7:0]     symbol_count;
    logic           busy;

    phase_sched #(.PI(PI), .SYM_LEN_SHIFT(SLS)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .start            (start),
        .stop             (stop),
        .freq_offset      (freq_offset),
        .sample_in_stb    (sample_in_stb),
        .pilot_phase      (pilot_phase),
        .pilot_phase_valid(pilot_phase_valid),
        .phase            (phase),
        .phase_stb        (phase_stb),
        .sample_idx       (sample_idx),
        .symbol_count     (symbol_count),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases are plain integers; wrapping is done by repeated +/- 2*PI.
    function automatic int wrapm(input int x);
        int y;
        y = x;
        while (y > PI)  y -= 2 * PI;
        while (y < -PI) y += 2 * PI;
        return y;
    endfunction

    int m_mode = 0;   // 0 idle, 1 load, 2 track
    int m_acc = 0, m_inc = 0, m_corr = 0, m_pend = 0;
    bit m_pend_v = 1'b0;
    int m_phase = 0, m_idx = 0, m_cnt = 0;
    bit m_stb = 1'b0;

    always @(posedge clock) begin
        bit bnd;
        if (!reset) begin
            m_mode = 0; m_acc = 0; m_inc = 0; m_corr = 0; m_pend = 0;
            m_pend_v = 1'b0; m_phase = 0; m_stb = 1'b0; m_idx = 0; m_cnt = 0;
        end else begin
            m_stb = 1'b0;
            if (enable) begin
                if (m_mode == 0) begin
                    if (start && !stop) m_mode = 1;
                end else if (m_mode == 1) begin
                    m_inc = $signed(freq_offset);
                    m_acc = 0; m_corr = 0; m_pend_v = 1'b0; m_idx = 0; m_cnt = 0;
                    m_mode = stop ? 0 : 2;
                end else if (stop) begin
                    m_mode = 0;
                end else if (start) begin
                    m_mode = 1;
                end else begin
                    bnd = (m_idx == N - 1);
                    if (sample_in_stb) begin
                        m_phase = wrapm(m_acc + m_corr);
                        m_stb   = 1'b1;
`ifdef PHASE_SCHED_CP_ADVANCE_EN
                        m_acc = bnd ? wrapm(m_acc + 17 * m_inc) : wrapm(m_acc + m_inc);
`else
                        m_acc = wrapm(m_acc + m_inc);
`endif
                        m_idx = (m_idx + 1) % N;
                        if (bnd) begin
                            if (pilot_phase_valid) m_corr = $signed(pilot_phase);
                            else if (m_pend_v)     m_corr = m_pend;
                            m_pend_v = 1'b0;
                            if (m_cnt < 255) m_cnt++;
                        end
                    end
                    if (pilot_phase_valid && !(sample_in_stb && bnd)) begin
                        m_pend   = $signed(pilot_phase);
                        m_pend_v = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_on) begin
            check("model phase_stb", int'(phase_stb), int'(m_stb));
            check("model phase", int'($signed(phase)), m_phase);
            check("model sample_idx", int'(sample_idx), m_idx);
            check("model symbol_count", int'(symbol_count), m_cnt);
            check("model busy", int'(busy), int'(m_mode != 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int fo);
        freq_offset = 16'(fo);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic strobe(output int ph, output int st);
        sample_in_stb = 1'b1;
        tick();
        ph = $signed(phase);
        st = int'(phase_stb);
        sample_in_stb = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ph, st;
        int exp034[3];
        int exp035[4];
        exp034 = '{0, 100, 200};
        exp035 = '{0, 1000, -1216, -216};

        // Reset state
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        cmp_on = 1'b1;
        check("reset phase", int'($signed(phase)), 0);
        check("reset phase_stb", int'(phase_stb), 0);
        check("reset sample_idx", int'(sample_idx), 0);
        check("reset symbol_count", int'(symbol_count), 0);
        check("reset busy", int'(busy), 0);
        reset = 1'b1;
        tick();

        // Basic ramp, one-cycle latency
        do_start(100);
        check("track busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            strobe(ph, st);
            check("ramp100 stb", st, 1);
            check("ramp100 phase", ph, exp034[i]);
        end
        tick();
        check("ramp100 stb drops", int'(phase_stb), 0);

        // Wrap at +PI
        do_start(1000);
        for (int i = 0; i < 4; i++) begin
            strobe(ph, st);
            check("wrap1000 phase", ph, exp035[i]);
        end

        // Wrap at -PI
        do_start(-1500);
        strobe(ph, st); check("neg phase0", ph, 0);
        strobe(ph, st); check("neg phase1", ph, -1500);
        strobe(ph, st); check("neg phase2", ph, 216);

        // Pilot at sample 10 applies at the next symbol
        do_start(0);
        for (int i = 0; i < 65; i++) begin
            if (i == 10) begin
                pilot_phase = 16'(50);
                pilot_phase_valid = 1'b1;
            end
            strobe(ph, st);
            pilot_phase_valid = 1'b0;
            if (i == 10 || i == 63) check("pilot sym0 phase", ph, 0);
            if (i == 64) check("pilot sym1 phase", ph, 50);
        end
        check("pilot symbol_count", int'(symbol_count), 1);
        check("pilot sample_idx", int'(sample_idx), 1);

        // Newest pending wins; boundary pilot bypasses pending
        do_start(0);
        pilot_phase = 16'(30); pilot_phase_valid = 1'b1; tick();
        pilot_phase = 16'(40); tick();
        pilot_phase_valid = 1'b0;
        for (int i = 0; i < 129; i++) begin
            if (i == 100) begin pilot_phase = 16'(20); pilot_phase_valid = 1'b1; end
            if (i == 127) begin pilot_phase = 16'(70); pilot_phase_valid = 1'b1; end
            strobe(ph, st);
            pilot_phase_valid = 1'b0;
            if (i == 63)  check("newest sym0 phase", ph, 0);
            if (i == 64)  check("newest sym1 phase", ph, 40);
            if (i == 127) check("bypass sym1 last phase", ph, 40);
            if (i == 128) check("bypass sym2 phase", ph, 70);
        end
        check("bypass symbol_count", int'(symbol_count), 2);

        // Cyclic prefix advance at the boundary
        do_start(10);
        for (int i = 0; i < 65; i++) begin
            strobe(ph, st);
            if (i == 63) check("cp sample63 phase", ph, 630);
            if (i == 64) check("cp sample64 phase", ph, EXP_CP_64);
        end

        // Enable low freezes everything
        do_start(50);
        strobe(ph, st); check("en phase0", ph, 0);
        strobe(ph, st); check("en phase1", ph, 50);
        enable = 1'b0;
        start = 1'b1; sample_in_stb = 1'b1;
        pilot_phase = 16'(99); pilot_phase_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en frozen stb", int'(phase_stb), 0);
            check("en frozen idx", int'(sample_idx), 2);
            check("en frozen busy", int'(busy), 1);
        end
        start = 1'b0; sample_in_stb = 1'b0; pilot_phase_valid = 1'b0;
        enable = 1'b1;
        strobe(ph, st); check("en resume phase", ph, 100);

        // start and stop together in TRACK: stop wins
        start = 1'b1; stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0;
        check("startstop busy", int'(busy), 0);
        strobe(ph, st); check("idle strobe ignored", st, 0);

        // stop while in LOAD returns to IDLE
        start = 1'b1; tick(); start = 1'b0;
        check("load busy", int'(busy), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop in load busy", int'(busy), 0);
        strobe(ph, st); check("after load stop strobe", st, 0);

        // Reset mid-TRACK
        do_start(7);
        for (int i = 0; i < 20; i++) strobe(ph, st);
        check("pre-reset sample_idx", int'(sample_idx), 20);
        reset = 1'b0; tick(); reset = 1'b1;
        check("midreset phase", int'($signed(phase)), 0);
        check("midreset stb", int'(phase_stb), 0);
        check("midreset idx", int'(sample_idx), 0);
        check("midreset symcnt", int'(symbol_count), 0);
        check("midreset busy", int'(busy), 0);
        do_start(7);
        strobe(ph, st); check("post-reset phase0", ph, 0);
        strobe(ph, st); check("post-reset phase1", ph, 7);

        // symbol_count saturation
        do_start(3);
        for (int i = 0; i < 257 * N; i++) strobe(ph, st);
        check("sat symbol_count", int'(symbol_count), 255);
        check("sat sample_idx", int'(sample_idx), 0);

        tick();
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
